// File: rtl/cheri_dmem_responder.sv
// cheri_dmem_responder
// Memory-side responder for the CHERIoT core data port. Requests are granted
// after WaitStates cycles. Granted accesses drive a single-port tagged SRAM
// with 1-cycle read latency. Each grant produces one response on the
// following cycle, carrying read data or a bus error.
// Optional feature: define CHERI_DMEM_TAGCLR_EN so that non-capability
// writes clear the stored tag bit.
module cheri_dmem_responder #(
    parameter logic [31:0] MemBase    = 32'h2004_0000,
    parameter int          MemAddrW   = 14,
    parameter int          WaitStates = 0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    input  logic                data_we_i,
    input  logic                data_is_cap_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [32:0]         data_wdata_i,
    output logic                data_rvalid_o,
    output logic [32:0]         data_rdata_o,
    output logic                data_err_o,
    output logic                mem_cs_o,
    output logic                mem_we_o,
    output logic [MemAddrW-1:0] mem_addr_o,
    output logic [4:0]          mem_bwe_o,
    output logic [32:0]         mem_wdata_o,
    input  logic [32:0]         mem_rdata_i
);

    localparam logic [32:0] WinBytes = 33'd4 << MemAddrW;
    localparam bit          HasWait  = (WaitStates > 0);
    localparam logic [2:0]  WaitLoad = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [0:0]  r_state;
    logic [2:0]  r_cnt;
    logic        r_rvalid;
    logic        r_err;
    logic        r_rd_pending;

    logic        w_gnt;
    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_misaligned;
    logic        w_err;
    logic        w_access;
    logic        w_tag_we;
    logic        w_tag_wdata;

    // Grant decision: immediate when there are no wait states, otherwise once the stall counter has run out.
    always_comb begin
        w_gnt = 1'b0;
        if (rstn_i && data_req_i) begin
            case (r_state)
                ST_IDLE:  w_gnt = !HasWait;
                ST_STALL: w_gnt = (r_cnt == 3'd0);
                default:  w_gnt = 1'b0;
            endcase
        end
    end

    // Wait-state FSM; a request withdrawn while stalling returns to IDLE without a grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (data_req_i && HasWait) begin
                        r_state <= ST_STALL;
                        r_cnt   <= WaitLoad;
                    end
                end
                ST_STALL: begin
                    if (!data_req_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                    end else if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Address decode and error classification. An address below MemBase wraps to a huge offset and fails the range test.
    always_comb begin
        w_offset     = data_addr_i - MemBase;
        w_in_range   = ({1'b0, w_offset} < WinBytes);
        w_misaligned = (data_addr_i[1:0] != 2'b00);
        w_err        = !w_in_range
                     || (data_is_cap_i && w_misaligned)
                     || (data_is_cap_i && data_we_i && (data_be_i != 4'hF));
        w_access     = w_gnt && !w_err;
    end

    // Tag write policy: capability writes store the tag; plain writes either clear it or leave it alone.
    always_comb begin
        w_tag_wdata = data_is_cap_i ? data_wdata_i[32] : 1'b0;
`ifdef CHERI_DMEM_TAGCLR_EN
        w_tag_we    = data_we_i && (data_is_cap_i || (data_be_i != 4'h0));
`else
        w_tag_we    = data_we_i && data_is_cap_i;
`endif
    end

    // SRAM drive; errored accesses never reach the macro.
    always_comb begin
        mem_cs_o    = w_access;
        mem_we_o    = w_access && data_we_i;
        mem_addr_o  = w_offset[MemAddrW+1:2];
        mem_wdata_o = {w_tag_wdata, data_wdata_i[31:0]};
        mem_bwe_o   = mem_we_o ? {w_tag_we, data_be_i} : 5'b0;
    end

    // Response pipeline: one response per grant, one cycle later, aligned with the SRAM read latency.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rd_pending <= 1'b0;
        end else begin
            r_rvalid     <= w_gnt;
            r_err        <= w_gnt && w_err;
            r_rd_pending <= w_access && !data_we_i;
        end
    end

    // Response outputs; read data is only forwarded for a successful read and is zero otherwise.
    always_comb begin
        data_gnt_o    = w_gnt;
        data_rvalid_o = r_rvalid;
        data_err_o    = r_err;
        data_rdata_o  = (r_rvalid && r_rd_pending) ? mem_rdata_i : 33'd0;
    end

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// tb_cheri_dmem_responder
// Two responders (zero and three wait states) with behavioural SRAMs. Requests
// are checked against an array-based reference model, and expected responses
// are queued for an independent monitor.
module tb_cheri_dmem_responder;

    localparam logic [31:0] MemBase  = 32'h2004_0000;
    localparam int          MemAddrW = 10;
    localparam int          Words    = 1 << MemAddrW;
    localparam logic [31:0] WinBytes = 32'(4 << MemAddrW);
`ifdef CHERI_DMEM_TAGCLR_EN
    localparam bit TagClr = 1'b1;
`else
    localparam bit TagClr = 1'b0;
`endif

    typedef struct {
        logic [32:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic [1:0]                    req, we, isCap, gnt, rvalid, err, mcs, mwe;
    logic [1:0][3:0]               be;
    logic [1:0][31:0]              addr;
    logic [1:0][32:0]              wdata, rdata, mwdata, mrdata;
    logic [1:0][4:0]               mbwe;
    logic [1:0][MemAddrW-1:0]      maddr;

    logic [32:0] sram   [2][Words];
    logic [32:0] refMem [2][Words];
    logic        memInit;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc     = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cheri_dmem_responder #(.MemBase(MemBase), .MemAddrW(MemAddrW), .WaitStates(0)) u_dut0 (
        .clk_i(clk), .rstn_i(rstn),
        .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_we_i(we[0]), .data_is_cap_i(isCap[0]),
        .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0]),
        .mem_cs_o(mcs[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_bwe_o(mbwe[0]),
        .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0])
    );

    cheri_dmem_responder #(.MemBase(MemBase), .MemAddrW(MemAddrW), .WaitStates(3)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_we_i(we[1]), .data_is_cap_i(isCap[1]),
        .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]),
        .mem_cs_o(mcs[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_bwe_o(mbwe[1]),
        .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1])
    );

    function automatic logic [32:0] initWord(input int d, input int i);
        logic [31:0] v;
        v = 32'(i) * 32'h9E37_79B1;
        v = v ^ (32'(d + 1) << 20);
        return {((i % 3) == 0), v};
    endfunction

    function automatic int expWaits(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Behavioural tagged SRAM for both responders: byte/tag write mask, registered read
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (memInit) begin
                for (int i = 0; i < Words; i++) sram[d][i] <= initWord(d, i);
            end else begin
                if (mcs[d] && mwe[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbwe[d][b]) sram[d][maddr[d]][8*b +: 8] <= mwdata[d][8*b +: 8];
                    if (mbwe[d][4]) sram[d][maddr[d]][32] <= mwdata[d][32];
                end
                if (mcs[d] && !mwe[d]) mrdata[d] <= sram[d][maddr[d]];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic int qSize(input int d);
        if (d == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic exp_t qFront(input int d);
        if (d == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qPop(input int d);
        if (d == 0) q0.delete(0);
        else q1.delete(0);
    endtask

    task automatic qPush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Reference model: decides the error, updates the word array and returns the expected response
    task automatic modelAccess(input int d, input logic w, input logic cap, input logic [3:0] b,
                               input logic [31:0] a, input logic [32:0] wd, output exp_t e);
        logic [31:0] off;
        int idx;
        off     = a - MemBase;
        e.err   = (off >= WinBytes) || (cap && (a % 4 != 0)) || (cap && w && b != 4'hF);
        e.rdata = '0;
        e.cyc   = cyc + 1;
        if (!e.err) begin
            idx = int'(off / 4);
            if (!w) begin
                e.rdata = refMem[d][idx];
            end else begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) refMem[d][idx][8*k +: 8] = wd[8*k +: 8];
                if (cap) refMem[d][idx][32] = wd[32];
                else if (TagClr && b != 4'h0) refMem[d][idx][32] = 1'b0;
            end
        end
    endtask

    // Present a request, wait (bounded) for its grant, then queue the expected response
    task automatic applyStimulus(input int d, input logic w, input logic cap, input logic [3:0] b,
                                 input logic [31:0] a, input logic [32:0] wd);
        int   waits;
        bit   got;
        exp_t e;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; isCap[d] = cap; be[d] = b; addr[d] = a; wdata[d] = wd;
        waits = 0;
        got   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (gnt[d]) begin
                got = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        check($sformatf("dut%0d grant seen", d), 64'(got), 64'd1);
        if (!got) begin
            req[d] = 1'b0;
            return;
        end
        check($sformatf("dut%0d wait cycles", d), 64'(waits), 64'(expWaits(d)));
        modelAccess(d, w, cap, b, a, wd, e);
        check($sformatf("dut%0d mem_cs at grant", d), 64'(mcs[d]), 64'(!e.err));
        qPush(d, e);
    endtask

    task automatic dropReq(input int d);
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    function automatic logic [31:0] randAddr();
        int c = $urandom_range(0, 9);
        int i = $urandom_range(0, 15);
        case (c)
            0:       return MemBase - 32'd4;
            1:       return MemBase + WinBytes;
            2:       return MemBase + WinBytes - 32'd4;
            3:       return MemBase + 32'(i * 4) + 32'($urandom_range(1, 3));
            default: return MemBase + 32'(i * 4);
        endcase
    endfunction

    // Monitor: compares each presented response against the head of the expected queue
    task automatic checkOutput(input int d);
        exp_t e;
        while (qSize(d) > 0 && qFront(d).cyc < cyc) begin
            check($sformatf("dut%0d rvalid missing", d), 64'd0, 64'd1);
            qPop(d);
        end
        if (rvalid[d]) begin
            if (qSize(d) == 0) begin
                check($sformatf("dut%0d unexpected rvalid", d), 64'd1, 64'd0);
            end else begin
                e = qFront(d);
                qPop(d);
                check($sformatf("dut%0d rvalid cycle", d), 64'(cyc), 64'(e.cyc));
                check($sformatf("dut%0d rdata", d), 64'(rdata[d]), 64'(e.rdata));
                check($sformatf("dut%0d err", d), 64'(err[d]), 64'(e.err));
            end
        end else begin
            check($sformatf("dut%0d rdata idle", d), 64'(rdata[d]), 64'd0);
        end
        check($sformatf("dut%0d gnt without req", d), 64'(gnt[d] & ~req[d]), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstn) begin
                checkOutput(0);
                checkOutput(1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetOutputs(input int d);
        check($sformatf("dut%0d reset gnt", d),    64'(gnt[d]),    64'd0);
        check($sformatf("dut%0d reset rvalid", d), 64'(rvalid[d]), 64'd0);
        check($sformatf("dut%0d reset rdata", d),  64'(rdata[d]),  64'd0);
        check($sformatf("dut%0d reset err", d),    64'(err[d]),    64'd0);
        check($sformatf("dut%0d reset mem_cs", d), 64'(mcs[d]),    64'd0);
        check($sformatf("dut%0d reset mem_we", d), 64'(mwe[d]),    64'd0);
    endtask

    initial begin
        rstn = 1'b1; memInit = 1'b1;
        req = '0; we = '0; isCap = '0; be = '0; addr = '0; wdata = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < Words; i++) refMem[d][i] = initWord(d, i);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        memInit = 1'b0;
        @(negedge clk);
        req[0] = 1'b1; addr[0] = MemBase; be[0] = 4'hF;
        #1;
        checkResetOutputs(0);
        checkResetOutputs(1);
        req[0] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] directed: read with zero wait states");
        applyStimulus(0, 1'b1, 1'b1, 4'hF, MemBase + 32'd8, 33'h1_DEAD_BEEF);
        applyStimulus(0, 1'b0, 1'b0, 4'hF, MemBase + 32'd8, 33'h0);
        dropReq(0);

        $display("[TB] directed: out-of-window accesses");
        applyStimulus(0, 1'b0, 1'b0, 4'hF, MemBase - 32'd4, 33'h0);
        applyStimulus(0, 1'b0, 1'b0, 4'hF, MemBase + WinBytes, 33'h0);
        dropReq(0);

        $display("[TB] directed: capability writes and tag handling");
        applyStimulus(0, 1'b1, 1'b1, 4'hF, MemBase + 32'h12, 33'h1_1234_5678);
        applyStimulus(0, 1'b1, 1'b1, 4'hF, MemBase + 32'h10, 33'h1_CAFE_F00D);
        applyStimulus(0, 1'b0, 1'b1, 4'hF, MemBase + 32'h10, 33'h0);
        applyStimulus(0, 1'b1, 1'b0, 4'b0001, MemBase + 32'h10, 33'h1_0000_00AA);
        applyStimulus(0, 1'b0, 1'b0, 4'hF, MemBase + 32'h10, 33'h0);
        dropReq(0);

        $display("[TB] directed: wait states and withdrawn request");
        applyStimulus(1, 1'b0, 1'b0, 4'hF, MemBase + 32'd4, 33'h0);
        dropReq(1);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; isCap[1] = 1'b0; be[1] = 4'hF; addr[1] = MemBase;
        #2 check("dut1 no gnt stall cycle 0", 64'(gnt[1]), 64'd0);
        @(negedge clk);
        #2 check("dut1 no gnt stall cycle 1", 64'(gnt[1]), 64'd0);
        @(negedge clk);
        req[1] = 1'b0;
        #2 check("dut1 no gnt after withdraw", 64'(gnt[1]), 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 4'hF, MemBase, 33'h0);
        dropReq(1);

        $display("[TB] random traffic");
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                applyStimulus(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                              randAddr(), {1'($urandom), 32'($urandom)});
                if ($urandom_range(0, 2) != 0) begin
                    dropReq(d);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            dropReq(d);
        end
        repeat (3) @(negedge clk);

        $display("[TB] directed: reset during back-to-back responses");
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 1'b0, 1'b0, 4'hF, MemBase + 32'(k * 4), 33'h0);
        #1 rstn = 1'b0;
        #1;
        checkResetOutputs(0);
        q0.delete();
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(0, 1'b0, 1'b0, 4'hF, MemBase + 32'd8, 33'h0);
        dropReq(0);

        repeat (5) @(negedge clk);
        check("dut0 queue drained", 64'(q0.size()), 64'd0);
        check("dut1 queue drained", 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
